// File: rtl/pkt_holding_fifo_pkg.sv
// Shared definitions for the packet holding FIFO: framing FSM states and
// the constant log2 helper used to size pointers.
package pkt_holding_fifo_pkg;

  // Packet framing state, shared by the input (write) and output (read) FSMs
  typedef enum logic {
    HDR     = 1'b0,
    PAYLOAD = 1'b1
  } frame_state_e;

  // Ceiling log2 for elaboration-time sizing
  function automatic int unsigned log2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << result) < 64'(value)) begin
        result = result + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/pkt_fifo_mem.sv
// Simple dual-port word store with fallthrough read. Pointers wrap naturally
// at DEPTH; full/empty tracking lives in the parent.
module pkt_fifo_mem
  import pkt_holding_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 72,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_word,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_word
);

  localparam int unsigned AW = log2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;

  // Pointer advance on each accepted write / read
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  // Pointer registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_word;
  end

  assign rd_word = mem_q[rd_ptr_q];

endmodule

// File: rtl/pkt_holding_fifo.sv
// Packet-aware holding FIFO on the NetFPGA data/ctrl bus. Supports
// store-and-forward (release only complete packets) and cut-through, with a
// forced release so packets larger than the FIFO cannot deadlock it.
module pkt_holding_fifo
  import pkt_holding_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned DEPTH_BITS = 6,
  parameter bit          STORE_FWD  = 1'b1,
  parameter int unsigned RDY_SLACK  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  mode_sf,
  output logic [DEPTH_BITS:0]   pkt_count,
  output logic [DEPTH_BITS:0]   word_count,
  output logic                  overflow,
  output logic                  forced_release
);

  localparam int unsigned       DEPTH   = 1 << DEPTH_BITS;
  localparam int unsigned       WORD_W  = CTRL_WIDTH + DATA_WIDTH;
  localparam logic [DEPTH_BITS:0] DEPTH_C = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] SLACK_C = (DEPTH_BITS + 1)'(RDY_SLACK);

  frame_state_e          in_state_q, in_state_d;
  frame_state_e          out_state_q, out_state_d;
  logic [DEPTH_BITS:0]   pkt_count_q, pkt_count_d;
  logic [DEPTH_BITS:0]   word_count_q, word_count_d;
  logic                  in_rdy_q, in_rdy_d;
  logic                  overflow_q, overflow_d;
  logic                  forced_q, forced_d;
  logic                  mode_act_q, mode_act_d;

  logic                  full, empty, allow;
  logic                  wr_en, rd_en, eop_wr, eop_rd;
  logic [WORD_W-1:0]     rd_word;

  assign full  = (word_count_q == DEPTH_C);
  assign empty = (word_count_q == '0);
  assign allow = !mode_act_q || (pkt_count_q != '0) || forced_q;
  assign rd_en = !empty && out_rdy && allow;
  // A read in the same cycle frees the slot, so a write at full is still taken
  assign wr_en = in_wr && (!full || rd_en);

  assign eop_wr = wr_en && (in_state_q == PAYLOAD) && (in_ctrl != '0);
  assign eop_rd = rd_en && (out_state_q == PAYLOAD) && (out_ctrl != '0);

  pkt_fifo_mem #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_word ({in_ctrl, in_data}),
    .rd_en   (rd_en),
    .rd_word (rd_word)
  );

  assign out_ctrl = rd_word[WORD_W-1 -: CTRL_WIDTH];
  assign out_data = rd_word[DATA_WIDTH-1:0];

  // Framing FSMs: payload starts on a ctrl==0 word, ends on the next ctrl!=0 word
  always_comb begin
    in_state_d  = in_state_q;
    out_state_d = out_state_q;
    if (wr_en) begin
      if (in_state_q == HDR && in_ctrl == '0)         in_state_d = PAYLOAD;
      else if (in_state_q == PAYLOAD && in_ctrl != '0) in_state_d = HDR;
    end
    if (rd_en) begin
      if (out_state_q == HDR && out_ctrl == '0)         out_state_d = PAYLOAD;
      else if (out_state_q == PAYLOAD && out_ctrl != '0) out_state_d = HDR;
    end
  end

  // Occupancy counters, flow-control, overflow, mode and forced-release next state
  always_comb begin
    word_count_d = word_count_q;
    pkt_count_d  = pkt_count_q;
    forced_d     = forced_q;
    mode_act_d   = mode_act_q;

    case ({wr_en, rd_en})
      2'b10:   word_count_d = word_count_q + 1'b1;
      2'b01:   word_count_d = word_count_q - 1'b1;
      default: word_count_d = word_count_q;
    endcase

    case ({eop_wr, eop_rd})
      2'b10:   pkt_count_d = pkt_count_q + 1'b1;
      2'b01:   pkt_count_d = pkt_count_q - 1'b1;
      default: pkt_count_d = pkt_count_q;
    endcase

    in_rdy_d   = (DEPTH_C - word_count_d) > SLACK_C;
    overflow_d = in_wr && !wr_en;

    // Clear wins: the EOP read that ends the oversize packet drops the release
    if (eop_rd)                                       forced_d = 1'b0;
    else if (mode_act_q && full && pkt_count_q == '0) forced_d = 1'b1;

    if (empty && in_state_q == HDR) mode_act_d = mode_sf;
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_state_q   <= HDR;
      out_state_q  <= HDR;
      pkt_count_q  <= '0;
      word_count_q <= '0;
      in_rdy_q     <= 1'b1;
      overflow_q   <= 1'b0;
      forced_q     <= 1'b0;
      mode_act_q   <= STORE_FWD;
    end else begin
      in_state_q   <= in_state_d;
      out_state_q  <= out_state_d;
      pkt_count_q  <= pkt_count_d;
      word_count_q <= word_count_d;
      in_rdy_q     <= in_rdy_d;
      overflow_q   <= overflow_d;
      forced_q     <= forced_d;
      mode_act_q   <= mode_act_d;
    end
  end

  assign in_rdy         = in_rdy_q;
  assign out_wr         = rd_en;
  assign pkt_count      = pkt_count_q;
  assign word_count     = word_count_q;
  assign overflow       = overflow_q;
  assign forced_release = forced_q;

endmodule

// File: doc/pkt_holding_fifo.md
Name: pkt_holding_fifo

Overview:
- Parametrised successor to the word-level holding FIFO in the user data path. It buffers the NetFPGA data/ctrl bus and adds a selectable store-and-forward mode.
- Store-and-forward: a packet is released only once its last word is stored.
- Cut-through: a word is released as soon as it is stored.
- Sits between user data path stages: upstream uses in_wr/in_rdy, downstream uses out_wr/out_rdy.

Parameters:
- DATA_WIDTH, 64, data bus width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl bus width.
- DEPTH_BITS, 6, log2 of the word capacity. DEPTH = 2^DEPTH_BITS.
- STORE_FWD, 1, reset value of the mode: 1 = store-and-forward, 0 = cut-through.
- RDY_SLACK, 2, in_rdy drops when free words <= RDY_SLACK.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  DATA_WIDTH  input word.
- in_ctrl  in  CTRL_WIDTH  input ctrl.
- in_wr  in  1  write strobe.
- in_rdy  out  1  upstream may write.
- out_data  out  DATA_WIDTH  head word (fallthrough).
- out_ctrl  out  CTRL_WIDTH  head ctrl.
- out_wr  out  1  head word is consumed this cycle.
- out_rdy  in  1  downstream can accept.
- mode_sf  in  1  runtime mode. Sampled only while the FIFO is empty and the input FSM is in HDR.
- pkt_count  out  DEPTH_BITS+1  complete packets held.
- word_count  out  DEPTH_BITS+1  words held.
- overflow  out  1  one-cycle pulse when a write is attempted while full.
- forced_release  out  1  high while an oversize packet is being cut through.

Behaviour:
- Reset values: all counters 0, both FSMs in HDR, forced_release 0, overflow 0, active mode = STORE_FWD, out_wr 0, in_rdy 1.
- Reset mid-packet discards all contents. Reset is asserted asynchronously and released synchronously to clk.
- Packet framing, input FSM:
  - HDR to PAYLOAD on a written word with ctrl == 0.
  - PAYLOAD to HDR on a written word with ctrl != 0. That word is EOP.
  - The output FSM applies the same rule to words read.
- Write: occurs when in_wr=1 and not full.
  - in_wr=1 while full: word dropped, overflow pulses next cycle, FSM unchanged.
- in_rdy = (DEPTH - word_count) > RDY_SLACK. Registered from word_count; no combinational path from in_wr.
- Read gate: allow = !mode_act || pkt_count != 0 || forced_release.
- out_wr = !empty && out_rdy && allow. Combinational, zero latency. Reads are fallthrough.
- pkt_count:
  - +1 on EOP write, -1 on EOP read, unchanged if both happen in the same cycle.
  - Never underflows: a read EOP always follows its write.
- word_count: +1 on write, -1 on read, unchanged when both occur in the same cycle.
- Oversize packets in store-and-forward mode:
  - When word_count == DEPTH and pkt_count == 0, set forced_release.
  - Cleared on the cycle an EOP is read.
  - Stops deadlock on packets longer than DEPTH.
- Simultaneous read and write when full is legal: the write is accepted because the read frees the slot in the same cycle.
- mode_sf changes outside the sampling window are ignored until the next window.
- Wrap-around: read and write pointers are DEPTH_BITS wide and wrap naturally.
- Full/empty are derived from word_count.

Decomposition:
- Shared package/include: the LOG2 function and the FSM state encodings HDR=0, PAYLOAD=1, used by both framing FSMs.
- One sub-module, pkt_fifo_mem: simple dual-port, DEPTH x (CTRL_WIDTH+DATA_WIDTH), fallthrough read, async active-low reset of its pointers.
- Top level holds the framing FSMs, counters, gating and forced-release logic.

Test Plan:
- Cut-through mode (mode_sf=0), 1 header word (ctrl=FF) + 4 data words + EOP (ctrl=01), out_rdy=1 → each word appears on out_wr in the same cycle it is visible, order preserved; pkt_count returns to 0.
- Store-and-forward, same 6-word packet → out_wr stays 0 until the cycle after the EOP write; pkt_count=1, then 6 consecutive out_wr, then pkt_count=0.
- DEPTH=64, 70-word packet in store-and-forward with out_rdy=1 → forced_release rises when word_count=64, words drain, forced_release clears on EOP read, all 70 words arrive intact.
- out_rdy=0, fill to DEPTH-2 → in_rdy=0. Extra writes up to full are accepted; a write at full pulses overflow and that word is absent at the output.
- Two back-to-back packets with out_rdy toggling, and a simultaneous EOP write and EOP read → pkt_count is unchanged on that cycle and never wraps negative.
- reset_n asserted mid-packet → outputs go to their reset values immediately; a following packet passes cleanly.
